// File: rtl/tile_map_pkg.sv
// Shared definitions for the tile-map renderer: sprite type codes, colours,
// the renderer FSM state encoding and the orb geometry helper.
package tile_map_pkg;

    // Sprite type codes held in map memory
    localparam int TILE_BLACK     = 0;
    localparam int TILE_BIG_ORB   = 1;
    localparam int TILE_SMALL_ORB = 2;
    localparam int TILE_WALL_BLUE = 3;
    localparam int TILE_WALL_GREY = 4;

    // Palette indices understood by the VGA adapter
    localparam int COL_BLACK = 0;
    localparam int COL_BLUE  = 1;
    localparam int COL_GREY  = 2;
    localparam int COL_WHITE = 7;

    // Renderer FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_D = 3'd2,
        DRAW    = 3'd3,
        DONE    = 3'd4
    } state_t;

    // True when pixel index p lies inside a span of 'size' pixels centred in a
    // tile of 'tile' pixels (odd leftover goes to the right/bottom side).
    function automatic logic in_orb(input int tile, input int size, input int p);
        int off;
        off = (tile - size) / 2;
        return (p >= off) && (p < off + size);
    endfunction

endpackage

// File: rtl/tile_sprite_rom.sv
// Combinational sprite pattern ROM: maps (type, px, py) to the pattern bit
// and the sprite's colour. Orb sizes scale with TILE: big = TILE-2,
// small = (TILE-1)/2, both centred. The colour output is the sprite colour;
// masking with the pattern bit is left to the caller.
module tile_sprite_rom
    import tile_map_pkg::*;
#(
    parameter int TILE    = 5,
    parameter int TYPE_W  = 3,
    parameter int COLOR_W = 3,
    parameter int PW      = 3
) (
    input  logic [TYPE_W-1:0]  sprite_type,
    input  logic [PW-1:0]      px,
    input  logic [PW-1:0]      py,
    output logic               pix_bit,
    output logic [COLOR_W-1:0] pix_color
);

    localparam int BIG_SIZE   = TILE - 2;
    localparam int SMALL_SIZE = (TILE - 1) / 2;

    // Pattern lookup per sprite type
    always_comb begin
        pix_bit   = 1'b0;
        pix_color = COLOR_W'(COL_BLACK);
        case (sprite_type)
            TYPE_W'(TILE_BLACK): begin
                pix_bit   = 1'b0;
                pix_color = COLOR_W'(COL_BLACK);
            end
            TYPE_W'(TILE_BIG_ORB): begin
                pix_bit   = in_orb(TILE, BIG_SIZE, int'(px)) && in_orb(TILE, BIG_SIZE, int'(py));
                pix_color = COLOR_W'(COL_WHITE);
            end
            TYPE_W'(TILE_SMALL_ORB): begin
                pix_bit   = in_orb(TILE, SMALL_SIZE, int'(px)) && in_orb(TILE, SMALL_SIZE, int'(py));
                pix_color = COLOR_W'(COL_WHITE);
            end
            TYPE_W'(TILE_WALL_BLUE): begin
                pix_bit   = 1'b1;
                pix_color = COLOR_W'(COL_BLUE);
            end
            default: begin
                pix_bit   = 1'b1;
                pix_color = COLOR_W'(COL_GREY);
            end
        endcase
    end

endmodule

// File: rtl/tile_map_renderer.sv
// Tile-map renderer: walks the MAP_W x MAP_H map, fetches each tile type
// through a 1-cycle registered map read port and plots it as a TILE x TILE
// sprite through the VGA pixel-write port with vga_ready backpressure.
//
// Handshake: a pixel is transferred on every rising edge where
// vga_plot && vga_ready; while vga_plot is high and vga_ready is low the
// pixel (vga_plot, vga_x, vga_y, vga_color) is held unchanged.
//
// Build option: define TILE_MAP_SKIP_BLANK_EN to suppress plotting of blank
// pattern pixels (they still take one cycle each, regardless of vga_ready).
module tile_map_renderer
    import tile_map_pkg::*;
#(
    parameter int MAP_W   = 21,
    parameter int MAP_H   = 21,
    parameter int TILE    = 5,
    parameter int TYPE_W  = 3,
    parameter int COLOR_W = 3,
    parameter int COORD_W = 8
) (
    input  logic                       clock_50,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(MAP_W)-1:0]   map_x,
    output logic [$clog2(MAP_H)-1:0]   map_y,
    input  logic [TYPE_W-1:0]          sprite_type,
    output logic                       vga_plot,
    input  logic                       vga_ready,
    output logic [COORD_W-1:0]         vga_x,
    output logic [COORD_W-1:0]         vga_y,
    output logic [COLOR_W-1:0]         vga_color,
    output logic [2:0]                 state_dbg
);

    localparam int XW = $clog2(MAP_W);
    localparam int YW = $clog2(MAP_H);
    localparam int PW = $clog2(TILE + 1);

    state_t              state;
    logic [TYPE_W-1:0]   tile_type;
    logic [PW-1:0]       px;
    logic [PW-1:0]       py;

    logic [PW-1:0]       nxt_px;
    logic [PW-1:0]       nxt_py;
    logic [TYPE_W-1:0]   rom_type;
    logic                rom_bit;
    logic [COLOR_W-1:0]  rom_color;
    logic [COLOR_W-1:0]  pix_color;
    logic                plot_next;
    logic [COORD_W-1:0]  base_x;
    logic [COORD_W-1:0]  base_y;
    logic                px_last;
    logic                py_last;
    logic                tile_last;
    logic                row_last;
    logic                advance;

    assign state_dbg = state;

    tile_sprite_rom #(
        .TILE    (TILE),
        .TYPE_W  (TYPE_W),
        .COLOR_W (COLOR_W),
        .PW      (PW)
    ) u_rom (
        .sprite_type (rom_type),
        .px          (nxt_px),
        .py          (nxt_py),
        .pix_bit     (rom_bit),
        .pix_color   (rom_color)
    );

`ifdef TILE_MAP_SKIP_BLANK_EN
    assign plot_next = rom_bit;
`else
    assign plot_next = 1'b1;
`endif

    // Next-pixel selection and coordinate arithmetic. In FETCH_D the tile
    // type is not latched yet, so the first pixel is looked up straight from
    // the map data; afterwards the latched type is used.
    always_comb begin
        px_last   = (px == PW'(TILE - 1));
        py_last   = (py == PW'(TILE - 1));
        row_last  = (map_x == XW'(MAP_W - 1));
        tile_last = row_last && (map_y == YW'(MAP_H - 1));
        advance   = !vga_plot || vga_ready;
        base_x    = COORD_W'(map_x) * COORD_W'(TILE);
        base_y    = COORD_W'(map_y) * COORD_W'(TILE);
        rom_type  = tile_type;
        nxt_px    = '0;
        nxt_py    = '0;
        if (state == FETCH_D) begin
            rom_type = sprite_type;
        end else if (px_last) begin
            nxt_py = py + 1'b1;
        end else begin
            nxt_px = px + 1'b1;
            nxt_py = py;
        end
        pix_color = rom_bit ? rom_color : COLOR_W'(COL_BLACK);
    end

    // FSM, tile/pixel counters and registered VGA outputs
    always_ff @(posedge clock_50) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            map_x     <= '0;
            map_y     <= '0;
            tile_type <= '0;
            px        <= '0;
            py        <= '0;
            vga_plot  <= 1'b0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH_A;
                        busy  <= 1'b1;
                        map_x <= '0;
                        map_y <= '0;
                    end
                end
                FETCH_A: begin
                    state <= FETCH_D;
                end
                FETCH_D: begin
                    tile_type <= sprite_type;
                    px        <= '0;
                    py        <= '0;
                    state     <= DRAW;
                    vga_plot  <= plot_next;
                    vga_x     <= base_x + COORD_W'(nxt_px);
                    vga_y     <= base_y + COORD_W'(nxt_py);
                    vga_color <= pix_color;
                end
                DRAW: begin
                    if (advance) begin
                        if (px_last && py_last) begin
                            vga_plot <= 1'b0;
                            if (tile_last) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= FETCH_A;
                                if (row_last) begin
                                    map_x <= '0;
                                    map_y <= map_y + 1'b1;
                                end else begin
                                    map_x <= map_x + 1'b1;
                                end
                            end
                        end else begin
                            px        <= nxt_px;
                            py        <= nxt_py;
                            vga_plot  <= plot_next;
                            vga_x     <= base_x + COORD_W'(nxt_px);
                            vga_y     <= base_y + COORD_W'(nxt_py);
                            vga_color <= pix_color;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
